// File: rtl/cmd_physical_pkg.sv
// -----------------------------------------------------------------------------
// cmd_physical_pkg
// Shared definitions for the SD-style CMD line physical layer:
//   - phy_state_t : controller state encoding
//   - frame geometry (48-bit frame, 38-bit {index, arg} payload)
//   - CRC7 generator polynomial and field bit positions within a frame
// Frame bit numbering: bit 47 is the first bit on the wire (start bit),
// bit 0 is the last (end bit).
// -----------------------------------------------------------------------------
package cmd_physical_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        SEND      = 3'd1,
        TURN      = 3'd2,
        WAIT_RESP = 3'd3,
        RECEIVE   = 3'd4,
        RESP_HS   = 3'd5,
        RELEASE   = 3'd6
    } phy_state_t;

    localparam int FRAME_LEN = 48;
    localparam int CMD_BITS  = 38;
    localparam int IDX_W     = 6;
    localparam int ARG_W     = 32;
    localparam int CRC_W     = 7;

    // x^7 + x^3 + 1 (the x^7 term is implicit in the shift-out)
    localparam logic [CRC_W-1:0] CRC7_POLY = 7'h09;

    // Field positions inside a frame
    localparam int START_POS   = 47;
    localparam int TRANS_POS   = 46;
    localparam int PAYLOAD_MSB = 45;
    localparam int PAYLOAD_LSB = 8;
    localparam int CRC_MSB     = 7;
    localparam int CRC_LSB     = 1;
    localparam int END_POS     = 0;

    // Number of leading frame bits covered by the CRC (start..payload)
    localparam int CRC_COVER_BITS = FRAME_LEN - CRC_W - 1;

endpackage

// File: rtl/crc7_serial.sv
// -----------------------------------------------------------------------------
// crc7_serial
// Bit-serial CRC7 (x^7 + x^3 + 1), one data bit per enabled clock.
// Ports:
//   clk      : clock (rising edge)
//   srst     : synchronous active-high reset, clears the CRC
//   clear    : synchronous clear to 0 (priority over enable)
//   enable   : absorb data_in this cycle
//   data_in  : serial data bit, MSB of the message first
//   crc_out  : current CRC remainder
// -----------------------------------------------------------------------------
module crc7_serial
    import cmd_physical_pkg::*;
(
    input  logic             clk,
    input  logic             srst,
    input  logic             clear,
    input  logic             enable,
    input  logic             data_in,
    output logic [CRC_W-1:0] crc_out
);

    logic [CRC_W-1:0] crc_reg;
    logic [CRC_W-1:0] crc_next;
    logic             feedback;

    assign feedback = data_in ^ crc_reg[CRC_W-1];

    // Shift left, folding the feedback bit in at every polynomial tap
    assign crc_next[0] = feedback & CRC7_POLY[0];

    genvar gi;
    generate
        for (gi = 1; gi < CRC_W; gi++) begin : g_tap
            assign crc_next[gi] = crc_reg[gi-1] ^ (feedback & CRC7_POLY[gi]);
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (srst || clear) begin
            crc_reg <= '0;
        end else if (enable) begin
            crc_reg <= crc_next;
        end
    end

    assign crc_out = crc_reg;

endmodule

// File: rtl/cmd_physical.sv
// -----------------------------------------------------------------------------
// cmd_physical
// Physical layer of the CMD line: serialises a {index, arg} command into a
// 48-bit frame with CRC7, turns the line around, waits (with timeout) for a
// response start bit, deserialises and checks the response, then hands the
// result back to the master via a REQ/ACK handshake.
// Ports:
//   CLK_host        : sole clock, rising edge
//   reset           : synchronous active-high reset
//   cmd_to_physical : {index[5:0], arg[31:0]} to send
//   REQ_in / ACK_out: command request / capture acknowledge
//   REQ_out / ACK_in: result valid / master acknowledge of result
//   cmd_response    : received {index, arg} (0 after a timeout)
//   timeout_error   : no start bit seen within timeout_value cycles
//   crc_error       : response transmission bit, CRC7 or end bit wrong
//   waiting_cmd     : high only while idle
//   timeout_value   : response wait limit in cycles
//   cmd_pin_out/oe  : CMD line drive / output enable
//   cmd_pin_in      : sampled CMD line
// -----------------------------------------------------------------------------
module cmd_physical
    import cmd_physical_pkg::*;
#(
    parameter int NCR_CYCLES = 2,
    parameter int TIMEOUT_W  = 16
) (
    input  logic                 CLK_host,
    input  logic                 reset,
    input  logic [CMD_BITS-1:0]  cmd_to_physical,
    input  logic                 REQ_in,
    output logic                 ACK_out,
    output logic                 REQ_out,
    input  logic                 ACK_in,
    output logic [CMD_BITS-1:0]  cmd_response,
    output logic                 timeout_error,
    output logic                 crc_error,
    output logic                 waiting_cmd,
    input  logic [TIMEOUT_W-1:0] timeout_value,
    output logic                 cmd_pin_out,
    output logic                 cmd_pin_oe,
    input  logic                 cmd_pin_in
);

    localparam logic [5:0] LAST_BIT     = 6'(FRAME_LEN - 1);       // 47
    localparam logic [5:0] TX_CRC_START = 6'(CRC_COVER_BITS);      // 40
    localparam logic [5:0] RX_LAST      = 6'(FRAME_LEN - 2);       // 46
    localparam logic [5:0] RX_CRC_LAST  = 6'(CRC_COVER_BITS - 2);  // 38
    localparam int         TURN_LAST_I  = (NCR_CYCLES > 0) ? NCR_CYCLES - 1 : 0;
    localparam logic [5:0] TURN_LAST    = 6'(TURN_LAST_I);

    phy_state_t state_reg, state_next;

    logic [5:0]                bit_cnt_reg;   // position within SEND/TURN/RECEIVE
    logic [TIMEOUT_W-1:0]      wait_cnt_reg;
    logic [CRC_COVER_BITS-1:0] tx_shift_reg;  // start, trans, index, arg
    logic [FRAME_LEN-3:0]      rx_shift_reg;  // response bits 46..1 once complete
    logic                      req_armed_reg; // REQ_in seen low since last capture
    logic                      ack_reg;
    logic [CMD_BITS-1:0]       resp_reg;
    logic                      timeout_reg;
    logic                      crc_err_reg;

    logic                      crc_clear;
    logic                      crc_enable;
    logic                      crc_data;
    logic [CRC_W-1:0]          crc_value;

    logic                      capture;
    logic                      start_bit;
    logic                      timeout_hit;
    logic [FRAME_LEN-2:0]      rx_tail;       // frame bits 46..0 at the last RECEIVE cycle
    logic                      rx_bad;

    assign capture     = (state_reg == IDLE) && REQ_in && req_armed_reg;
    assign start_bit   = (cmd_pin_in == 1'b0);
    assign timeout_hit = (wait_cnt_reg == timeout_value);
    assign rx_tail     = {rx_shift_reg, cmd_pin_in};
    assign rx_bad      = (rx_tail[TRANS_POS] != 1'b0)
                      || (crc_value != rx_tail[CRC_MSB:CRC_LSB])
                      || (rx_tail[END_POS] != 1'b1);

    crc7_serial u_crc (
        .clk     (CLK_host),
        .srst    (reset),
        .clear   (crc_clear),
        .enable  (crc_enable),
        .data_in (crc_data),
        .crc_out (crc_value)
    );

    // Next state, line drive and CRC control
    always_comb begin
        state_next  = state_reg;
        crc_clear   = 1'b0;
        crc_enable  = 1'b0;
        crc_data    = 1'b0;
        cmd_pin_oe  = 1'b0;
        cmd_pin_out = 1'b1;

        case (state_reg)
            IDLE: begin
                crc_clear = 1'b1;
                if (capture) begin
                    state_next = SEND;
                end
            end

            SEND: begin
                cmd_pin_oe = 1'b1;
                if (bit_cnt_reg < TX_CRC_START) begin
                    cmd_pin_out = tx_shift_reg[CRC_COVER_BITS-1];
                    crc_enable  = 1'b1;
                    crc_data    = tx_shift_reg[CRC_COVER_BITS-1];
                end else if (bit_cnt_reg < LAST_BIT) begin
                    // CRC is frozen after bit 39; emit it MSB first
                    cmd_pin_out = crc_value[3'(LAST_BIT - 6'd1 - bit_cnt_reg)];
                end else begin
                    cmd_pin_out = 1'b1;
                end
                if (bit_cnt_reg == LAST_BIT) begin
                    state_next = (NCR_CYCLES > 0) ? TURN : WAIT_RESP;
                end
            end

            TURN: begin
                if (bit_cnt_reg == TURN_LAST) begin
                    state_next = WAIT_RESP;
                end
            end

            WAIT_RESP: begin
                // The start bit is 0, so a CRC cleared here equals one that
                // has absorbed the start bit: RECEIVE can begin from zero.
                crc_clear = 1'b1;
                if (start_bit) begin
                    state_next = RECEIVE;
                end else if (timeout_hit) begin
                    state_next = RESP_HS;
                end
            end

            RECEIVE: begin
                if (bit_cnt_reg <= RX_CRC_LAST) begin
                    crc_enable = 1'b1;
                    crc_data   = cmd_pin_in;
                end
                if (bit_cnt_reg == RX_LAST) begin
                    state_next = RESP_HS;
                end
            end

            RESP_HS: begin
                if (ACK_in) begin
                    state_next = RELEASE;
                end
            end

            RELEASE: begin
                if (!ACK_in) begin
                    state_next = IDLE;
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK_host) begin
        if (reset) begin
            state_reg     <= IDLE;
            bit_cnt_reg   <= '0;
            wait_cnt_reg  <= '0;
            tx_shift_reg  <= '0;
            rx_shift_reg  <= '0;
            req_armed_reg <= 1'b0;
            ack_reg       <= 1'b0;
            resp_reg      <= '0;
            timeout_reg   <= 1'b0;
            crc_err_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;

            // A new capture needs REQ_in to have been seen low first, which
            // also blocks a request held high through reset.
            if (!REQ_in) begin
                req_armed_reg <= 1'b1;
            end else if (capture) begin
                req_armed_reg <= 1'b0;
            end

            if (capture) begin
                ack_reg <= 1'b1;
            end else if (!REQ_in) begin
                ack_reg <= 1'b0;
            end

            case (state_reg)
                IDLE: begin
                    if (capture) begin
                        tx_shift_reg <= {1'b0, 1'b1, cmd_to_physical};
                        bit_cnt_reg  <= '0;
                        timeout_reg  <= 1'b0;
                        crc_err_reg  <= 1'b0;
                    end
                end

                SEND: begin
                    tx_shift_reg <= {tx_shift_reg[CRC_COVER_BITS-2:0], 1'b0};
                    wait_cnt_reg <= '0;
                    bit_cnt_reg  <= (bit_cnt_reg == LAST_BIT) ? 6'd0 : bit_cnt_reg + 6'd1;
                end

                TURN: begin
                    bit_cnt_reg <= (bit_cnt_reg == TURN_LAST) ? 6'd0 : bit_cnt_reg + 6'd1;
                end

                WAIT_RESP: begin
                    if (start_bit) begin
                        rx_shift_reg <= '0;
                        bit_cnt_reg  <= '0;
                    end else if (timeout_hit) begin
                        timeout_reg <= 1'b1;
                        resp_reg    <= '0;
                    end else begin
                        wait_cnt_reg <= wait_cnt_reg + TIMEOUT_W'(1);
                    end
                end

                RECEIVE: begin
                    rx_shift_reg <= {rx_shift_reg[FRAME_LEN-4:0], cmd_pin_in};
                    if (bit_cnt_reg == RX_LAST) begin
                        bit_cnt_reg <= '0;
                        resp_reg    <= rx_tail[PAYLOAD_MSB:PAYLOAD_LSB];
                        crc_err_reg <= rx_bad;
                    end else begin
                        bit_cnt_reg <= bit_cnt_reg + 6'd1;
                    end
                end

                default: begin
                end
            endcase
        end
    end

    assign ACK_out       = ack_reg;
    assign REQ_out       = (state_reg == RESP_HS);
    assign waiting_cmd   = (state_reg == IDLE);
    assign cmd_response  = resp_reg;
    assign timeout_error = timeout_reg;
    assign crc_error     = crc_err_reg;

endmodule

// File: tb/tb_cmd_physical.sv
// -----------------------------------------------------------------------------
// tb_cmd_physical
// Directed bench for cmd_physical: reset state, command serialisation and
// CRC7, ACK handshake, response reception with good/bad CRC, timeout and its
// boundaries, reset mid-frame and REQ_in activity outside IDLE.
// -----------------------------------------------------------------------------
module tb_cmd_physical;

    logic        CLK_host = 1'b0;
    logic        reset = 1'b1;
    logic [37:0] cmd_to_physical = '0;
    logic        REQ_in = 1'b0;
    logic        ACK_out;
    logic        REQ_out;
    logic        ACK_in = 1'b0;
    logic [37:0] cmd_response;
    logic        timeout_error;
    logic        crc_error;
    logic        waiting_cmd;
    logic [15:0] timeout_value = 16'd100;
    logic        cmd_pin_out;
    logic        cmd_pin_oe;
    logic        cmd_pin_in = 1'b1;

    int vectors = 0;
    int miscompares = 0;

    localparam logic [37:0] CMD0      = {6'd0, 32'd0};
    localparam logic [37:0] CMD8      = {6'd8, 32'h0000_01AA};
    localparam logic [47:0] CMD0_FR   = 48'h40_0000_0000_95;
    localparam logic [47:0] CMD8_FR   = 48'h48_0000_01AA_87;
    localparam logic [47:0] RESP_OK   = 48'h37_0000_0120_83;
    localparam logic [47:0] RESP_BAD  = 48'h37_0000_0121_83;
    localparam logic [37:0] RESP_PAY  = {6'h37, 32'h0000_0120};
    localparam logic [37:0] RESP_BPAY = {6'h37, 32'h0000_0121};

    always #5 CLK_host = ~CLK_host;

    cmd_physical #(.NCR_CYCLES(2), .TIMEOUT_W(16)) dut (
        .CLK_host        (CLK_host),
        .reset           (reset),
        .cmd_to_physical (cmd_to_physical),
        .REQ_in          (REQ_in),
        .ACK_out         (ACK_out),
        .REQ_out         (REQ_out),
        .ACK_in          (ACK_in),
        .cmd_response    (cmd_response),
        .timeout_error   (timeout_error),
        .crc_error       (crc_error),
        .waiting_cmd     (waiting_cmd),
        .timeout_value   (timeout_value),
        .cmd_pin_out     (cmd_pin_out),
        .cmd_pin_oe      (cmd_pin_oe),
        .cmd_pin_in      (cmd_pin_in)
    );

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge CLK_host);
        #1;
    endtask

    // Request a command and record the 48 bits driven on the line
    task automatic send_cmd(input logic [37:0] cmd, output logic [47:0] frame,
                            output int oe_cnt, output logic ack1, output logic ack2);
        cmd_to_physical = cmd;
        REQ_in = 1'b1;
        frame  = '0;
        oe_cnt = 0;
        ack2   = 1'bx;
        tick;
        ack1   = ACK_out;
        frame  = {frame[46:0], cmd_pin_out};
        oe_cnt += int'(cmd_pin_oe);
        REQ_in = 1'b0;
        for (int i = 1; i < 48; i++) begin
            tick;
            if (i == 1) ack2 = ACK_out;
            frame = {frame[46:0], cmd_pin_out};
            oe_cnt += int'(cmd_pin_oe);
        end
    endtask

    // Called right after send_cmd: move through TURN, idle in WAIT_RESP, then
    // play a response frame; optionally pulse REQ_in while bit pulse_at is on the line
    task automatic drive_resp(input logic [47:0] frame, input int idle, input int pulse_at,
                              output logic ack_seen, output logic req_early);
        repeat (3 + idle) tick;
        ack_seen  = 1'b0;
        req_early = 1'b0;
        for (int i = 47; i >= 0; i--) begin
            cmd_pin_in = frame[i];
            REQ_in     = (i == pulse_at);
            tick;
            ack_seen = ack_seen | ACK_out;
            if (i > 0) req_early = req_early | REQ_out;
        end
        cmd_pin_in = 1'b1;
        REQ_in     = 1'b0;
    endtask

    task automatic release_hs;
        ACK_in = 1'b1;
        tick;
        ACK_in = 1'b0;
        tick;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (3) tick;
        vectors++; if (ACK_out !== 1'b0) begin miscompares++; $display("FAIL reset_ack: got %b want 0", ACK_out); end
        vectors++; if (REQ_out !== 1'b0) begin miscompares++; $display("FAIL reset_req_out: got %b want 0", REQ_out); end
        vectors++; if (timeout_error !== 1'b0) begin miscompares++; $display("FAIL reset_timeout: got %b want 0", timeout_error); end
        vectors++; if (crc_error !== 1'b0) begin miscompares++; $display("FAIL reset_crc: got %b want 0", crc_error); end
        vectors++; if (cmd_response !== 38'd0) begin miscompares++; $display("FAIL reset_resp: got %h want 0", cmd_response); end
        vectors++; if (cmd_pin_oe !== 1'b0) begin miscompares++; $display("FAIL reset_oe: got %b want 0", cmd_pin_oe); end
        vectors++; if (cmd_pin_out !== 1'b1) begin miscompares++; $display("FAIL reset_pin: got %b want 1", cmd_pin_out); end
        vectors++; if (waiting_cmd !== 1'b1) begin miscompares++; $display("FAIL reset_waiting: got %b want 1", waiting_cmd); end
        reset = 1'b0;
        tick;
        $display("reset released, waiting_cmd=%b", waiting_cmd);
    endtask

    // CMD0 frame, ACK handshake, and timeout_value=0 timing out on the first wait cycle
    task automatic test_cmd0;
        logic [47:0] fr;
        int oe;
        logic a1, a2;
        timeout_value = 16'd0;
        send_cmd(CMD0, fr, oe, a1, a2);
        $display("cmd0 sent frame=%h oe_cycles=%0d", fr, oe);
        vectors++; if (fr !== CMD0_FR) begin miscompares++; $display("FAIL cmd0_frame: got %h want %h", fr, CMD0_FR); end
        vectors++; if (oe !== 48) begin miscompares++; $display("FAIL cmd0_oe_cycles: got %0d want 48", oe); end
        vectors++; if (a1 !== 1'b1) begin miscompares++; $display("FAIL cmd0_ack_rise: got %b want 1", a1); end
        vectors++; if (a2 !== 1'b0) begin miscompares++; $display("FAIL cmd0_ack_fall: got %b want 0", a2); end
        tick;
        vectors++; if ({cmd_pin_oe, cmd_pin_out} !== 2'b01) begin miscompares++; $display("FAIL cmd0_turn_line: got oe,pin=%b want 01", {cmd_pin_oe, cmd_pin_out}); end
        repeat (2) tick;
        vectors++; if (REQ_out !== 1'b0) begin miscompares++; $display("FAIL cmd0_no_early_timeout: got %b want 0", REQ_out); end
        tick;
        vectors++; if ({REQ_out, timeout_error} !== 2'b11) begin miscompares++; $display("FAIL cmd0_timeout0: got req,to=%b want 11", {REQ_out, timeout_error}); end
        vectors++; if (cmd_response !== 38'd0) begin miscompares++; $display("FAIL cmd0_resp_zero: got %h want 0", cmd_response); end
        release_hs;
        vectors++; if (waiting_cmd !== 1'b1) begin miscompares++; $display("FAIL cmd0_idle: got %b want 1", waiting_cmd); end
    endtask

    task automatic test_cmd8_response;
        logic [47:0] fr;
        int oe;
        logic a1, a2, ack_seen, early;
        timeout_value = 16'd100;
        send_cmd(CMD8, fr, oe, a1, a2);
        $display("cmd8 sent frame=%h", fr);
        vectors++; if (fr !== CMD8_FR) begin miscompares++; $display("FAIL cmd8_frame: got %h want %h", fr, CMD8_FR); end
        drive_resp(RESP_OK, 2, -1, ack_seen, early);
        $display("cmd8 response resp=%h crc_err=%b req_out=%b", cmd_response, crc_error, REQ_out);
        vectors++; if (early !== 1'b0) begin miscompares++; $display("FAIL cmd8_req_early: got %b want 0", early); end
        vectors++; if (REQ_out !== 1'b1) begin miscompares++; $display("FAIL cmd8_req_out: got %b want 1", REQ_out); end
        vectors++; if (cmd_response !== RESP_PAY) begin miscompares++; $display("FAIL cmd8_resp: got %h want %h", cmd_response, RESP_PAY); end
        vectors++; if ({crc_error, timeout_error} !== 2'b00) begin miscompares++; $display("FAIL cmd8_flags: got crc,to=%b want 00", {crc_error, timeout_error}); end
        repeat (3) tick;
        vectors++; if (REQ_out !== 1'b1) begin miscompares++; $display("FAIL cmd8_req_hold: got %b want 1", REQ_out); end
        ACK_in = 1'b1;
        tick;
        vectors++; if ({REQ_out, waiting_cmd} !== 2'b00) begin miscompares++; $display("FAIL cmd8_release: got req,wait=%b want 00", {REQ_out, waiting_cmd}); end
        tick;
        vectors++; if (waiting_cmd !== 1'b0) begin miscompares++; $display("FAIL cmd8_release_hold: got %b want 0", waiting_cmd); end
        ACK_in = 1'b0;
        tick;
        vectors++; if (waiting_cmd !== 1'b1) begin miscompares++; $display("FAIL cmd8_idle: got %b want 1", waiting_cmd); end
        vectors++; if (cmd_response !== RESP_PAY) begin miscompares++; $display("FAIL cmd8_resp_hold: got %h want %h", cmd_response, RESP_PAY); end
    endtask

    task automatic test_crc_error;
        logic [47:0] fr;
        int oe;
        logic a1, a2, ack_seen, early;
        send_cmd(CMD8, fr, oe, a1, a2);
        drive_resp(RESP_BAD, 0, -1, ack_seen, early);
        $display("bad-crc response resp=%h crc_err=%b", cmd_response, crc_error);
        vectors++; if (crc_error !== 1'b1) begin miscompares++; $display("FAIL crc_flag: got %b want 1", crc_error); end
        vectors++; if (cmd_response !== RESP_BPAY) begin miscompares++; $display("FAIL crc_resp: got %h want %h", cmd_response, RESP_BPAY); end
        release_hs;
    endtask

    task automatic test_timeout;
        logic [47:0] fr;
        int oe;
        logic a1, a2, ack_seen, early;
        timeout_value = 16'd15;
        send_cmd(CMD8, fr, oe, a1, a2);
        repeat (3 + 15) tick;
        vectors++; if ({REQ_out, timeout_error} !== 2'b00) begin miscompares++; $display("FAIL to15_early: got req,to=%b want 00", {REQ_out, timeout_error}); end
        tick;
        $display("timeout 15 to=%b resp=%h", timeout_error, cmd_response);
        vectors++; if ({REQ_out, timeout_error} !== 2'b11) begin miscompares++; $display("FAIL to15_hit: got req,to=%b want 11", {REQ_out, timeout_error}); end
        vectors++; if (cmd_response !== 38'd0) begin miscompares++; $display("FAIL to15_resp: got %h want 0", cmd_response); end
        release_hs;
        // Start bit on the very cycle the timeout would fire
        send_cmd(CMD8, fr, oe, a1, a2);
        drive_resp(RESP_OK, 15, -1, ack_seen, early);
        $display("start-on-timeout to=%b resp=%h", timeout_error, cmd_response);
        vectors++; if ({REQ_out, timeout_error, crc_error} !== 3'b100) begin miscompares++; $display("FAIL start_wins: got req,to,crc=%b want 100", {REQ_out, timeout_error, crc_error}); end
        vectors++; if (cmd_response !== RESP_PAY) begin miscompares++; $display("FAIL start_wins_resp: got %h want %h", cmd_response, RESP_PAY); end
        release_hs;
    endtask

    task automatic test_reset_mid_send;
        int n;
        timeout_value = 16'd0;
        cmd_to_physical = CMD8;
        REQ_in = 1'b1;
        tick;
        repeat (20) tick;
        vectors++; if (cmd_pin_oe !== 1'b1) begin miscompares++; $display("FAIL midsend_oe: got %b want 1", cmd_pin_oe); end
        reset = 1'b1;
        tick;
        reset = 1'b0;
        $display("reset at bit 20 oe=%b pin=%b waiting=%b", cmd_pin_oe, cmd_pin_out, waiting_cmd);
        vectors++; if ({cmd_pin_oe, cmd_pin_out, waiting_cmd, ACK_out, REQ_out} !== 5'b01100) begin miscompares++; $display("FAIL midsend_abort: got oe,pin,wait,ack,req=%b want 01100", {cmd_pin_oe, cmd_pin_out, waiting_cmd, ACK_out, REQ_out}); end
        repeat (5) tick;
        vectors++; if ({waiting_cmd, cmd_pin_oe, ACK_out} !== 3'b100) begin miscompares++; $display("FAIL held_req_no_capture: got wait,oe,ack=%b want 100", {waiting_cmd, cmd_pin_oe, ACK_out}); end
        REQ_in = 1'b0;
        tick;
        REQ_in = 1'b1;
        tick;
        vectors++; if ({ACK_out, cmd_pin_oe, waiting_cmd} !== 3'b110) begin miscompares++; $display("FAIL recapture: got ack,oe,wait=%b want 110", {ACK_out, cmd_pin_oe, waiting_cmd}); end
        REQ_in = 1'b0;
        n = 0;
        while (REQ_out !== 1'b1 && n < 100) begin
            tick;
            n++;
        end
        vectors++; if ({REQ_out, timeout_error} !== 2'b11) begin miscompares++; $display("FAIL recapture_done: got req,to=%b want 11 after %0d cycles", {REQ_out, timeout_error}, n); end
        release_hs;
    endtask

    task automatic test_req_during_receive;
        logic [47:0] fr;
        int oe;
        logic a1, a2, ack_seen, early;
        timeout_value = 16'd100;
        send_cmd(CMD8, fr, oe, a1, a2);
        drive_resp(RESP_OK, 1, 20, ack_seen, early);
        $display("REQ_in pulse in RECEIVE ack_seen=%b", ack_seen);
        vectors++; if (ack_seen !== 1'b0) begin miscompares++; $display("FAIL rx_req_ack: got %b want 0", ack_seen); end
        vectors++; if ({REQ_out, crc_error} !== 2'b10) begin miscompares++; $display("FAIL rx_req_result: got req,crc=%b want 10", {REQ_out, crc_error}); end
        release_hs;
        tick;
        vectors++; if ({waiting_cmd, cmd_pin_oe, ACK_out} !== 3'b100) begin miscompares++; $display("FAIL rx_req_no_capture: got wait,oe,ack=%b want 100", {waiting_cmd, cmd_pin_oe, ACK_out}); end
    endtask

    initial begin
        test_reset;
        test_cmd0;
        test_cmd8_response;
        test_crc_error;
        test_timeout;
        test_reset_mid_send;
        test_req_during_receive;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/cmd_physical.md
CMD_PHYSICAL -- requirements
Module: cmd_physical

Interface
REQ-001 SHALL have parameter NCR_CYCLES, default 2: minimum turnaround cycles after the command end bit before the response start bit is sampled.
REQ-002 SHALL have parameter TIMEOUT_W, default 16: width of timeout_value and of the wait counter.
REQ-003 SHALL have one clock and a synchronous, active-high reset:
- CLK_host  in  1  sole clock; all logic on rising edge
- reset  in  1  synchronous active-high reset
REQ-004 SHALL have the following ports:
- cmd_to_physical  in  38  {index[5:0], arg[31:0]} from CMD_master
- REQ_in  in  1  master request: cmd_to_physical valid
- ACK_out  out  1  acknowledge of captured command
- REQ_out  out  1  response/timeout result valid
- ACK_in  in  1  master acknowledge of result
- cmd_response  out  38  received {index, arg}
- timeout_error  out  1  no response start bit within timeout_value
- crc_error  out  1  response frame check failed
- waiting_cmd  out  1  high only in IDLE
- timeout_value  in  TIMEOUT_W  response wait limit in cycles
- cmd_pin_out  out  1  serial CMD line drive
- cmd_pin_oe  out  1  CMD line output enable
- cmd_pin_in  in  1  sampled CMD line

Function
REQ-005 SHALL use states IDLE, SEND, TURN, WAIT_RESP, RECEIVE, RESP_HS, RELEASE.
REQ-006 IDLE: when REQ_in=1 is sampled after REQ_in has been seen low since the last command, the block SHALL capture cmd_to_physical, clear timeout_error/crc_error, and enter SEND.
REQ-007 ACK_out SHALL rise the cycle after capture, stay high until REQ_in is sampled low, and fall the next cycle; REQ_in is ignored outside IDLE.
REQ-008 SEND: the block SHALL drive the 48-bit frame MSB first, one bit per cycle, cmd_pin_oe=1 for exactly 48 cycles.
- Frame: start 0, transmission 1, index[5:0], arg[31:0], CRC7[6:0], end 1.
- The first bit is driven on the cycle after capture.
REQ-009 CRC7 SHALL use polynomial x^7+x^3+1, initial value 0, computed over the first 40 frame bits.
REQ-010 TURN: cmd_pin_oe=0 and cmd_pin_out=1 for NCR_CYCLES cycles, then WAIT_RESP.
REQ-011 WAIT_RESP: a counter SHALL start at 0 and increment each cycle.
- cmd_pin_in=0 sampled: treat as response bit 47 and enter RECEIVE.
- Otherwise, when counter==timeout_value: set timeout_error=1 and cmd_response=0, enter RESP_HS.
- timeout_value=0 with the line high: timeout on the first WAIT_RESP cycle.
- A start bit on the timeout cycle wins over the timeout.
REQ-012 RECEIVE: the block SHALL shift in 47 further bits.
- cmd_response = bits[45:8].
- crc_error=1 if transmission bit[46]≠0, CRC7 over bits[47:8]≠bits[7:1], or end bit[0]≠1.
- Then enter RESP_HS.
REQ-013 RESP_HS: REQ_out=1 until ACK_in is sampled high, then REQ_out=0 and enter RELEASE; cmd_response and error flags are stable while REQ_out=1.
REQ-014 RELEASE: wait for ACK_in low, then IDLE; results hold until the next capture.
REQ-015 Outside SEND, cmd_pin_oe=0 and cmd_pin_out=1.

Reset
REQ-016 reset SHALL force from any state, effective the next edge:
- state=IDLE, counters=0
- ACK_out=0, REQ_out=0, timeout_error=0, crc_error=0, cmd_response=0
- cmd_pin_oe=0, cmd_pin_out=1, waiting_cmd=1
REQ-017 Reset asserted mid-SEND/RECEIVE SHALL abort the frame with no REQ_out; if REQ_in is held high through reset, a new capture SHALL occur only after REQ_in has been seen low.

Structure
REQ-018 The shared package SHALL hold: state encoding, FRAME_LEN=48, CMD_BITS=38, CRC7 polynomial constant, field bit positions.
REQ-019 Sub-module crc7_serial SHALL be used: clear, enable, data bit in; 7-bit CRC out; instantiated once each for transmit and receive, or time-shared.

Verification
REQ-020 The bench SHALL cover:
- cmd_to_physical={6'd0,32'd0}, REQ_in=1 -> serial stream 48'h40_0000_0000_95, ACK_out handshake per REQ-007.
- cmd {6'd8,32'h0000_01AA} -> stream 48'h48_0000_01AA_87; then inject response 48'h37_0000_0120_83 -> cmd_response={6'h37,32'h0000_0120}, crc_error=0, REQ_out until ACK_in.
- Same response with arg bit 0 flipped -> crc_error=1, cmd_response shows the flipped arg.
- timeout_value=15, line held high -> timeout_error=1 exactly 16 WAIT_RESP cycles in, cmd_response=0.
- Reset at bit 20 of SEND -> next cycle oe=0, pin=1, IDLE; REQ_in held high -> no capture until toggled low/high.
- REQ_in pulsed during RECEIVE -> ignored, ACK_out stays 0.
